// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample sample points
// and the majority-vote helper used to decide each bit.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int DATA_BITS  = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick prescaler: one-cycle tick every CLKS_PER_TICK clocks,
// restartable with a synchronous clear so bit timing aligns to a start edge.
module uart_tick_gen #(
    parameter int CLKS_PER_TICK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with 3-sample majority vote, optional parity,
// stop-bit check and a valid/ready holding register with sticky overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 4,
    parameter int OVERSAMPLE    = 16,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_err
);

    logic rx_meta_reg;
    logic rx_s_reg;
    logic rx_prev_reg;
    logic fall;
    logic tick;
    logic tick_clr;

    rx_state_t state_reg, state_next;
    logic [3:0] tcnt_reg, tcnt_next, tcnt_inc;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic       s_lo_reg, s_lo_next;
    logic       s_mid_reg, s_mid_next;
    logic       p_err_reg, p_err_next;
    logic       bit_val;
    logic       data_cap;
    logic       commit;

    logic [DATA_BITS-1:0] data_reg, data_next;

    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 parity_err_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;
    logic                 pop;
    logic                 load;
    logic                 drop;

    // Line idles high, so the synchroniser resets to 1 to avoid a fake start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    assign fall     = rx_prev_reg & ~rx_s_reg;
    assign tick_clr = (state_reg == IDLE) && fall;

    uart_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    assign tcnt_inc = (tcnt_reg == 4'(OVERSAMPLE - 1)) ? 4'd0 : tcnt_reg + 4'd1;
    assign bit_val  = maj3(s_lo_reg, s_mid_reg, rx_s_reg);

    always_comb begin
        state_next   = state_reg;
        tcnt_next    = tcnt_reg;
        bit_idx_next = bit_idx_reg;
        p_err_next   = p_err_reg;
        s_lo_next    = s_lo_reg;
        s_mid_next   = s_mid_reg;
        data_cap     = 1'b0;
        commit       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    tcnt_next  = 4'd0;
                end
            end
            BRK_WAIT: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (tick) begin
                    tcnt_next = tcnt_inc;
                    if (tcnt_inc == 4'(SAMPLE_LO)) begin
                        s_lo_next = rx_s_reg;
                    end
                    if (tcnt_inc == 4'(SAMPLE_MID)) begin
                        s_mid_next = rx_s_reg;
                    end
                    // The third sample is the live rx_s at the decision tick.
                    if (tcnt_inc == 4'(SAMPLE_HI)) begin
                        case (state_reg)
                            START: begin
                                if (bit_val) begin
                                    state_next = IDLE;
                                end else begin
                                    state_next   = DATA;
                                    bit_idx_next = 3'd0;
                                    p_err_next   = 1'b0;
                                end
                            end
                            DATA: begin
                                data_cap = 1'b1;
                                if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
                                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                                end else begin
                                    bit_idx_next = bit_idx_reg + 3'd1;
                                end
                            end
                            PARITY: begin
                                p_err_next = ((^data_reg) ^ bit_val) != 1'(PARITY_ODD);
                                state_next = STOP;
                            end
                            STOP: begin
                                commit     = 1'b1;
                                state_next = bit_val ? IDLE : BRK_WAIT;
                            end
                            default: begin
                                state_next = IDLE;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_data_bit
        assign data_next[gi] = (data_cap && (bit_idx_reg == 3'(gi))) ? bit_val : data_reg[gi];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            tcnt_reg    <= 4'd0;
            bit_idx_reg <= 3'd0;
            s_lo_reg    <= 1'b1;
            s_mid_reg   <= 1'b1;
            p_err_reg   <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            tcnt_reg    <= tcnt_next;
            bit_idx_reg <= bit_idx_next;
            s_lo_reg    <= s_lo_next;
            s_mid_reg   <= s_mid_next;
            p_err_reg   <= p_err_next;
            data_reg    <= data_next;
        end
    end

    // A pop in the same cycle frees the slot, so the new byte loads instead of overrunning.
    assign pop  = rx_valid_reg & rx_ready;
    assign load = commit & (~rx_valid_reg | pop);
    assign drop = commit & rx_valid_reg & ~rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else if (load) begin
            rx_data_reg    <= data_reg;
            rx_valid_reg   <= 1'b1;
            parity_err_reg <= p_err_reg;
            frame_err_reg  <= ~bit_val;
        end else if (pop) begin
            rx_valid_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_reg <= 1'b0;
        end else if (drop) begin
            overrun_reg <= 1'b1;
        end else if (clr_err) begin
            overrun_reg <= 1'b0;
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: one 8N1 receiver and one 8E1 receiver,
// expected bytes queued as frames are driven and compared on every pop.
module tb_uart_rx_os;

    localparam int CPT      = 4;
    localparam int BIT_CLKS = 16 * CPT;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       rx_a = 1'b1, rx_ready_a = 1'b0, clr_err_a = 1'b0;
    logic [7:0] rx_data_a;
    logic       rx_valid_a, parity_err_a, frame_err_a, overrun_a;

    logic       rx_b = 1'b1, rx_ready_b = 1'b0, clr_err_b = 1'b0;
    logic [7:0] rx_data_b;
    logic       rx_valid_b, parity_err_b, frame_err_b, overrun_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   pops_a = 0, pops_b = 0;
    int   rise_a = 0, fall_a = 0, rise_b = 0;
    logic vprev_a = 1'b0, vprev_b = 1'b0;
    logic [9:0] part_fr;

    uart_rx_os #(
        .CLKS_PER_TICK(CPT), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a),
        .overrun(overrun_a), .clr_err(clr_err_a)
    );

    uart_rx_os #(
        .CLKS_PER_TICK(CPT), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b),
        .overrun(overrun_b), .clr_err(clr_err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int bclk,
                              input bit par, input logic pbit);
        logic [10:0] fr;
        int nb;
        if (par) begin
            fr = {1'b1, pbit, d, 1'b0};
            nb = 11;
        end else begin
            fr = {1'b1, 1'b1, d, 1'b0};
            nb = 10;
        end
        @(posedge clk); #1;
        start_cyc = cyc;
        for (int i = 0; i < nb; i++) begin
            drive_rx(sel, fr[i]);
            repeat (bclk) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (rx_valid_a && !vprev_a) rise_a = cyc;
            if (!rx_valid_a && vprev_a) fall_a = cyc;
            if (rx_valid_a && rx_ready_a) begin
                pops_a++;
                if (q_a.size() == 0) begin
                    check("a_unexpected_pop", 32'(q_a.size()), 32'd1);
                end else begin
                    e = q_a.pop_front();
                    $display("rx a @%0d: data=0x%02h perr=%0b ferr=%0b (want 0x%02h %0b %0b)",
                             cyc, rx_data_a, parity_err_a, frame_err_a, e.data, e.perr, e.ferr);
                    check("a_data", rx_data_a, e.data);
                    check("a_perr", parity_err_a, e.perr);
                    check("a_ferr", frame_err_a, e.ferr);
                end
            end
        end
        vprev_a = rx_valid_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (rx_valid_b && !vprev_b) rise_b = cyc;
            if (rx_valid_b && rx_ready_b) begin
                pops_b++;
                if (q_b.size() == 0) begin
                    check("b_unexpected_pop", 32'(q_b.size()), 32'd1);
                end else begin
                    e = q_b.pop_front();
                    $display("rx b @%0d: data=0x%02h perr=%0b ferr=%0b (want 0x%02h %0b %0b)",
                             cyc, rx_data_b, parity_err_b, frame_err_b, e.data, e.perr, e.ferr);
                    check("b_data", rx_data_b, e.data);
                    check("b_perr", parity_err_b, e.perr);
                    check("b_ferr", frame_err_b, e.ferr);
                end
            end
        end
        vprev_b = rx_valid_b;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: cycle %0d, test did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle(3);
        check("rst_data", rx_data_a, 8'h00);
        check("rst_valid", rx_valid_a, 1'b0);
        check("rst_perr", parity_err_a, 1'b0);
        check("rst_ferr", frame_err_a, 1'b0);
        check("rst_overrun", overrun_a, 1'b0);
        check("rst_valid_b", rx_valid_b, 1'b0);
        rst = 1'b1;
        rx_ready_a = 1'b1;
        rx_ready_b = 1'b1;
        idle(10);

        // Nominal 8N1 byte: latency and single-cycle valid pulse.
        q_a.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, BIT_CLKS, 0, 1'b0);
        idle(4);
        check("a5_latency", 32'(rise_a - start_cyc), 32'd615);
        check("a5_pulse", 32'(fall_a - rise_a), 32'd1);
        check("a5_pops", 32'(pops_a), 32'd1);

        // Short low glitch must be rejected as a false start.
        rx_a = 1'b0;
        idle(12);
        rx_a = 1'b1;
        idle(200);
        check("glitch_valid", rx_valid_a, 1'b0);
        check("glitch_pops", 32'(pops_a), 32'd1);

        // Even parity: wrong then correct parity bit.
        q_b.push_back('{8'h03, 1'b1, 1'b0});
        send_frame(1, 8'h03, BIT_CLKS, 1, 1'b1);
        idle(4);
        check("par_latency", 32'(rise_b - start_cyc), 32'd679);
        q_b.push_back('{8'h03, 1'b0, 1'b0});
        send_frame(1, 8'h03, BIT_CLKS, 1, 1'b0);
        idle(4);
        check("par_pops", 32'(pops_b), 32'd2);

        // Back-to-back with consumer stalled: second byte dropped.
        rx_ready_a = 1'b0;
        q_a.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(0, 8'h11, BIT_CLKS, 0, 1'b0);
        send_frame(0, 8'h22, BIT_CLKS, 0, 1'b0);
        idle(4);
        check("ovr_flag", overrun_a, 1'b1);
        check("ovr_valid", rx_valid_a, 1'b1);
        check("ovr_held", rx_data_a, 8'h11);
        clr_err_a = 1'b1;
        idle(1);
        clr_err_a = 1'b0;
        check("ovr_clr", overrun_a, 1'b0);
        check("ovr_still_valid", rx_valid_a, 1'b1);
        rx_ready_a = 1'b1;
        idle(2);
        check("ovr_pops", 32'(pops_a), 32'd2);
        check("ovr_empty", rx_valid_a, 1'b0);

        // Break: one zero byte with frame error, then nothing until line returns.
        q_a.push_back('{8'h00, 1'b0, 1'b1});
        rx_a = 1'b0;
        idle(20 * BIT_CLKS);
        check("brk_pops", 32'(pops_a), 32'd3);
        rx_a = 1'b1;
        idle(2 * BIT_CLKS);
        check("brk_pops_after", 32'(pops_a), 32'd3);
        q_a.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(0, 8'h5A, BIT_CLKS, 0, 1'b0);
        idle(4);
        check("post_brk_pops", 32'(pops_a), 32'd4);

        // Fill holding register and overrun, then reset mid-frame.
        rx_ready_a = 1'b0;
        send_frame(0, 8'h7E, BIT_CLKS, 0, 1'b0);
        send_frame(0, 8'h7E, BIT_CLKS, 0, 1'b0);
        idle(4);
        check("pre_rst_valid", rx_valid_a, 1'b1);
        check("pre_rst_overrun", overrun_a, 1'b1);
        part_fr = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_a = part_fr[i];
            idle(BIT_CLKS);
        end
        rx_a = part_fr[5];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_data", rx_data_a, 8'h00);
        check("mid_rst_valid", rx_valid_a, 1'b0);
        check("mid_rst_overrun", overrun_a, 1'b0);
        check("mid_rst_ferr", frame_err_a, 1'b0);
        rx_a = 1'b1;
        idle(5);
        rst = 1'b1;
        idle(BIT_CLKS);
        rx_ready_a = 1'b1;

        // Same byte at nominal rate and at -3 % / +3 % bit period.
        q_a.push_back('{8'hC3, 1'b0, 1'b0});
        send_frame(0, 8'hC3, BIT_CLKS, 0, 1'b0);
        q_a.push_back('{8'hC3, 1'b0, 1'b0});
        send_frame(0, 8'hC3, 62, 0, 1'b0);
        q_a.push_back('{8'hC3, 1'b0, 1'b0});
        send_frame(0, 8'hC3, 66, 0, 1'b0);
        idle(100);

        check("final_pops_a", 32'(pops_a), 32'd7);
        check("sb_a_empty", 32'(q_a.size()), 32'd0);
        check("sb_b_empty", 32'(q_b.size()), 32'd0);
        check("final_overrun", overrun_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver for the other end of the link driven by `uart_tx`. It resynchronises the asynchronous serial line and finds each frame's start edge on a 16x sample tick. Every bit is decided by a 3-sample majority vote, and the block checks parity and stop bit. Each received byte, together with its error flags, is presented on a valid/ready holding register that a consumer inside `top`-level integrations drains.

## Interface
- `CLKS_PER_TICK`, 4: clk cycles per oversample tick; must be ≥1.
- `OVERSAMPLE`, 16: ticks per bit; fixed at 16, with majority samples at ticks 7, 8 and 9.
- `PARITY_EN`, 0: 1 adds a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial line, asynchronous, idle high.
- `rx_data` out 8: received byte; reset 0.
- `rx_valid` out 1: holding register full; reset 0.
- `rx_ready` in 1: consumer accepts; a pop occurs when `rx_valid && rx_ready`.
- `parity_err` out 1: parity mismatch for the held byte; reset 0.
- `frame_err` out 1: stop bit sampled 0 for the held byte; reset 0.
- `overrun` out 1: sticky flag, set when a byte is dropped; reset 0.
- `clr_err` in 1: one-cycle pulse that clears `overrun`.

## Operation
- **Line input:** `rx` passes through a 2-flop synchroniser (both flops reset to 1), giving `rx_s`. A tick prescaler counts `CLKS_PER_TICK` and emits a one-cycle `tick`. A 4-bit `tcnt` counts ticks within the current bit.
- **IDLE:** a falling edge on `rx_s` clears the prescaler and `tcnt` to 0 and moves to START.
- **START:** at tcnt=9 the majority of the samples at ticks 7, 8 and 9 decides the bit.
  - Majority 1: false start, return to IDLE with nothing output.
  - Majority 0: move to DATA.
- **DATA:** 8 bits, LSB first, each 16 ticks long and decided at tcnt=9 by majority. `bit_idx` runs 0 to 7. After bit 7 the next state is PARITY if `PARITY_EN`, else STOP.
- **PARITY:** the decided bit is XORed with the 8 data bits. A result ≠ `PARITY_ODD` sets a local `p_err`.
- **STOP:** at the tcnt=9 decision, data, `p_err` and `f_err` (set when the stop bit is 0) are committed to the holding register.
  - Stop bit 1: go to IDLE at once, so a back-to-back start edge is caught within half a bit.
  - Stop bit 0: go to BRK_WAIT.
- **BRK_WAIT:** stay until `rx_s`=1, then go to IDLE. This covers the break condition: an all-zero byte with `frame_err`=1 is delivered once.
- **Holding register commit:**
  - Empty, or a pop in the same cycle: load the new byte and its flags; `rx_valid` is 1.
  - Full with no pop: discard the new byte, keep the old byte and flags, set `overrun`.
- **Pop with no commit:** `rx_valid` goes to 0. `rx_data` and the flags hold their last values.
- **Error flags:** `parity_err` and `frame_err` are per-byte and change only on load. `overrun` stays set until `clr_err`. If `clr_err` and a new overrun occur in the same cycle, set wins.
- **Reset mid-frame:** `rst` low at any time returns the FSM to IDLE and clears all outputs asynchronously.

## Timing
- Pin-to-`rx_s` latency is 2 cycles.
- Each bit decision falls at 9 ticks (9×`CLKS_PER_TICK` clks) after that bit's nominal start.
- `rx_valid` rises on the clk edge of the stop-bit decision. For 8N1 that is 2 + `CLKS_PER_TICK`·(16·9+9) clks after the start edge on the pin, with +1 clk for the edge-detect register.
  - At defaults: 2 + 4·153 + 1 = 615 clks.
  - `PARITY_EN` adds 16·`CLKS_PER_TICK` clks.
- A pop takes effect on the same edge where `rx_valid && rx_ready`; `rx_valid` is 0 in the next cycle unless a load coincides.
- The receiver tolerates ±3 % baud mismatch between transmitter and receiver.

## Structure
- **Package `uart_pkg`:**
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t`
  - `localparam SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9`
  - `localparam DATA_BITS=8`
  - The package is shared with future `uart_tx` updates.
- **Sub-module `uart_tick_gen`:** parameterised by `CLKS_PER_TICK`, with a synchronous clear input and a `tick` output. Reused by the transmitter side.
- Synchroniser, majority logic, FSM and holding register stay in `uart_rx_os`.

## Test plan
- 8N1 frame 0xA5 at nominal rate, `rx_ready`=1: `rx_data`=0xA5 and `rx_valid` pulses 1 cycle at clk 615; all error flags 0.
- 12-clk low glitch on idle `rx`: FSM returns to IDLE after START, `rx_valid` stays 0.
- `PARITY_EN`=1, even, byte 0x03 with parity bit 1: `rx_data`=0x03, `parity_err`=1. Repeat with correct parity 0: `parity_err`=0.
- Two back-to-back frames 0x11 then 0x22 with `rx_ready`=0: 0x11 is held, 0x22 is dropped and `overrun`=1. `clr_err` pulse clears `overrun`; popping yields 0x11.
- Break (`rx` low for 20 bit times): exactly one byte 0x00 with `frame_err`=1, no further bytes until `rx` high. A following 0x5A frame is received cleanly.
- `rst` asserted at data bit 4 of a frame: all outputs 0 immediately. The next full frame 0xC3 is received correctly; ±3 % baud skew on 0xC3 still passes.
